// File: rtl/uart_ram_dump.sv
//==============================================================================
// Module      : uart_ram_dump
// Description : Streams a block of 32-bit RAM words out as UART bytes, framed
//               by a header byte and followed by an XOR checksum byte.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_ram_dump #(
    parameter int         ADDR_WIDTH  = 10,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                  iGlobalClock,
    input  logic                  iGlobalReset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddr,
    input  logic [ADDR_WIDTH:0]   iWordCount,
    output logic [ADDR_WIDTH-1:0] oRamAddr,
    output logic                  oRamReadEnable,
    input  logic [31:0]           iRamData,
    output logic [7:0]            oUartTx,
    output logic                  oUartTxByteAvailable,
    input  logic                  iUartTxReady,
    output logic                  oBusy,
    output logic                  oDone
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HEADER   = 3'd1,
        S_READ     = 3'd2,
        S_LATCH    = 3'd3,
        S_SEND     = 3'd4,
        S_CHECKSUM = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [31:0]           r_shift;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_csum;
    logic [7:0]            r_tx;
    logic                  r_tx_valid;
    logic                  r_rd_en;
    logic                  r_busy;
    logic                  r_done;
    logic [7:0]            w_csum_next;

    // Checksum including the byte currently being handed to the transmitter
    assign w_csum_next = r_csum ^ r_tx;

    always_ff @(posedge iGlobalClock or negedge iGlobalReset) begin
        if (!iGlobalReset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_shift    <= '0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'h00;
            r_tx       <= 8'h00;
            r_tx_valid <= 1'b0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_addr  <= iBaseAddr;
                        r_count <= iWordCount;
                        r_csum  <= 8'h00;
                        r_busy  <= 1'b1;
                        if (iWordCount == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state    <= S_HEADER;
                            r_tx       <= HEADER_BYTE;
                            r_tx_valid <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (iUartTxReady) begin
                        r_tx_valid <= 1'b0;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift    <= iRamData;
                    r_tx       <= iRamData[31:24];
                    r_tx_valid <= 1'b1;
                    r_byte_idx <= 2'd0;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (iUartTxReady) begin
                        r_csum <= w_csum_next;
                        if (r_byte_idx == 2'd3) begin
                            r_addr  <= r_addr + c_ADDR_ONE;
                            r_count <= r_count - c_COUNT_ONE;
                            if (r_count == c_COUNT_ONE) begin
                                r_tx    <= w_csum_next;
                                r_state <= S_CHECKSUM;
                            end else begin
                                r_tx_valid <= 1'b0;
                                r_rd_en    <= 1'b1;
                                r_state    <= S_READ;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= {r_shift[23:0], 8'h00};
                            r_tx       <= r_shift[23:16];
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (iUartTxReady) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oRamAddr             = r_addr;
    assign oRamReadEnable       = r_rd_en;
    assign oUartTx              = r_tx;
    assign oUartTxByteAvailable = r_tx_valid;
    assign oBusy                = r_busy;
    assign oDone                = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_ram_dump.sv
//==============================================================================
// Module      : tb_uart_ram_dump
// Description : Directed, table-driven bench for uart_ram_dump with a RAM model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_ram_dump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base = '0;
    logic [10:0] count = '0;
    logic [9:0]  ram_addr;
    logic        ram_rd;
    logic [31:0] ram_q = '0;
    logic [7:0]  tx;
    logic        tx_valid;
    logic        ready = 1'b1;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    uart_ram_dump #(.ADDR_WIDTH(10), .HEADER_BYTE(8'hA5)) dut (
        .iGlobalClock        (clk),
        .iGlobalReset        (rst_n),
        .iStart              (start),
        .iBaseAddr           (base),
        .iWordCount          (count),
        .oRamAddr            (ram_addr),
        .oRamReadEnable      (ram_rd),
        .iRamData            (ram_q),
        .oUartTx             (tx),
        .oUartTxByteAvailable(tx_valid),
        .iUartTxReady        (ready),
        .oBusy               (busy),
        .oDone               (done)
    );

    logic [31:0] mem [0:1023];
    always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_bytes[$];
    logic [9:0] rd_addrs[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         hold_err = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b1;
    logic [7:0] prev_tx = 8'h00;

    // Transfers seen at the falling edge complete on the following rising edge
    always @(negedge clk) begin
        if (tx_valid && ready) got_bytes.push_back(tx);
        if (ram_rd) rd_addrs.push_back(ram_addr);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_valid && !prev_ready && (!tx_valid || tx != prev_tx)) hold_err = hold_err + 1;
        if (ram_rd && tx_valid) hold_err = hold_err + 1;
        prev_valid = tx_valid;
        prev_ready = ready;
        prev_tx    = tx;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]        base;
        logic [10:0]       count;
        logic [31:0]       d0;
        logic [31:0]       d1;
        int                stall_idx;
        int                stall_len;
        int                restart_at;
        int                nbytes;
        logic [0:15][7:0]  exp;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int id);
        logic [9:0] a1;
        logic [9:0] ea;
        int         stall_left;
        bit         restarted;
        int         k;
        a1 = v.base + 10'd1;
        mem[v.base] = v.d0;
        mem[a1]     = v.d1;
        got_bytes.delete();
        rd_addrs.delete();
        done_cnt = 0;
        hold_err = 0;
        base  = v.base;
        count = v.count;
        start = 1'b1;
        ready = 1'b1;
        begin
            int start_cyc;
            start_cyc = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("v%0d busy_after_start", id), {63'd0, busy}, 64'd1);
            stall_left = v.stall_len;
            restarted  = 1'b0;
            k = 0;
            while (done_cnt == 0 && k < 300) begin
                start = 1'b0;
                if (v.restart_at >= 0 && !restarted && got_bytes.size() == v.restart_at && tx_valid) begin
                    start = 1'b1;
                    base  = 10'd3;
                    count = 11'd5;
                    restarted = 1'b1;
                end
                if (stall_left > 0 && got_bytes.size() == v.stall_idx && tx_valid) begin
                    ready = 1'b0;
                    stall_left = stall_left - 1;
                end else begin
                    ready = 1'b1;
                end
                @(posedge clk); #1;
                k = k + 1;
            end
            start = 1'b0;
            ready = 1'b1;
            check($sformatf("v%0d done_seen", id), {63'd0, done_cnt > 0}, 64'd1);
            if (v.nbytes == 0)
                check($sformatf("v%0d done_latency", id), 64'(done_cyc - start_cyc), 64'd2);
        end
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("v%0d byte_count", id), 64'(got_bytes.size()), 64'(v.nbytes));
        for (int i = 0; i < v.nbytes; i++)
            check($sformatf("v%0d byte%0d", id, i),
                  (i < got_bytes.size()) ? {56'd0, got_bytes[i]} : 64'h1FF, {56'd0, v.exp[i]});
        check($sformatf("v%0d read_count", id), 64'(rd_addrs.size()), 64'(v.count));
        for (int i = 0; i < int'(v.count) && i < 2; i++) begin
            ea = v.base + 10'(i);
            check($sformatf("v%0d read_addr%0d", id, i),
                  (i < rd_addrs.size()) ? {54'd0, rd_addrs[i]} : 64'hFFFF, {54'd0, ea});
        end
        check($sformatf("v%0d done_pulses", id), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d hold_errors", id), 64'(hold_err), 64'd0);
        check($sformatf("v%0d idle_busy", id), {63'd0, busy}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        vecs[0] = '{base:10'h000, count:11'd2, d0:32'h6, d1:32'h8, stall_idx:-1, stall_len:0,
                    restart_at:-1, nbytes:10,
                    exp:{8'hA5,8'h00,8'h00,8'h00,8'h06,8'h00,8'h00,8'h00,8'h08,8'h0E,48'h0}};
        vecs[1] = '{base:10'h000, count:11'd2, d0:32'h6, d1:32'h8, stall_idx:4, stall_len:5,
                    restart_at:-1, nbytes:10,
                    exp:{8'hA5,8'h00,8'h00,8'h00,8'h06,8'h00,8'h00,8'h00,8'h08,8'h0E,48'h0}};
        vecs[2] = '{base:10'h3FF, count:11'd2, d0:32'hDEADBEEF, d1:32'h1, stall_idx:-1, stall_len:0,
                    restart_at:-1, nbytes:10,
                    exp:{8'hA5,8'hDE,8'hAD,8'hBE,8'hEF,8'h00,8'h00,8'h00,8'h01,8'h23,48'h0}};
        vecs[3] = '{base:10'h010, count:11'd0, d0:32'h11, d1:32'h22, stall_idx:-1, stall_len:0,
                    restart_at:-1, nbytes:0, exp:128'h0};
        vecs[4] = '{base:10'h007, count:11'd1, d0:32'hFF00FF00, d1:32'h0, stall_idx:5, stall_len:3,
                    restart_at:-1, nbytes:6,
                    exp:{8'hA5,8'hFF,8'h00,8'hFF,8'h00,8'h00,80'h0}};
        vecs[5] = '{base:10'h000, count:11'd2, d0:32'h6, d1:32'h8, stall_idx:0, stall_len:2,
                    restart_at:5, nbytes:10,
                    exp:{8'hA5,8'h00,8'h00,8'h00,8'h06,8'h00,8'h00,8'h00,8'h08,8'h0E,48'h0}};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {44'd0, ram_addr, ram_rd, tx, tx_valid, busy, done}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // Reset asserted while the third data byte is on offer
        mem[0] = 32'h6;
        mem[1] = 32'h8;
        got_bytes.delete();
        done_cnt = 0;
        base  = 10'h000;
        count = 11'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int k;
            k = 0;
            while (!(got_bytes.size() == 3 && tx_valid) && k < 100) begin
                @(posedge clk); #1;
                k = k + 1;
            end
            check("midreset_reached", {63'd0, k < 100}, 64'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", {44'd0, ram_addr, ram_rd, tx, tx_valid, busy, done}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(done_cnt), 64'd0);
        check("midreset_idle", {63'd0, busy}, 64'd0);
        check("midreset_no_more_bytes", 64'(got_bytes.size()), 64'd3);
        run_vec(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_ram_dump.md
UART_RAM_DUMP -- requirements
Module: uart_ram_dump

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: data-RAM address width.
REQ-002 SHALL have parameter HEADER_BYTE, default 8'hA5: frame start byte.
REQ-003 SHALL have port iGlobalClock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port iGlobalReset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port iStart, input, 1: one-cycle dump request.
REQ-006 SHALL have port iBaseAddr, input, ADDR_WIDTH: first word address, sampled on accepted iStart.
REQ-007 SHALL have port iWordCount, input, ADDR_WIDTH+1: number of 32-bit words, sampled on accepted iStart.
REQ-008 SHALL have port oRamAddr, output, ADDR_WIDTH: data-RAM read address.
REQ-009 SHALL have port oRamReadEnable, output, 1: RAM read strobe.
REQ-010 SHALL have port iRamData, input, 32: RAM read data, valid one cycle after the strobe.
REQ-011 SHALL have port oUartTx, output, 8: byte toward the UART transmitter.
REQ-012 SHALL have port oUartTxByteAvailable, output, 1: oUartTx valid.
REQ-013 SHALL have port iUartTxReady, input, 1: transmitter accepts the byte this cycle.
REQ-014 SHALL have port oBusy, output, 1: dump in progress.
REQ-015 SHALL have port oDone, output, 1: one-cycle dump-complete pulse.

Function
REQ-016 SHALL implement states IDLE, HEADER, READ, LATCH, SEND, CHECKSUM, DONE.
REQ-017 SHALL accept iStart only in IDLE; iStart in any other state is ignored, with no effect on counters or outputs.
REQ-018 SHALL, on an accepted iStart, go IDLE->DONE if iWordCount==0, else IDLE->HEADER, with the checksum cleared to 8'h00.
REQ-019 SHALL make a byte transfer occur only in a cycle where oUartTxByteAvailable and iUartTxReady are both 1.
REQ-020 SHALL hold oUartTx stable and oUartTxByteAvailable high until that byte transfers; no drop or change while iUartTxReady==0.
REQ-021 SHALL, in HEADER, present HEADER_BYTE; on transfer go to READ; the header is excluded from the checksum.
REQ-022 SHALL, in READ, assert oRamReadEnable for exactly one cycle with oRamAddr = current address, then go to LATCH.
REQ-023 SHALL, in LATCH, capture iRamData into a 32-bit shift register, then go to SEND.
REQ-024 SHALL, in SEND, emit four bytes MSB first ([31:24] first); the next byte is presented in the cycle after each transfer.
REQ-025 SHALL XOR every transferred data byte into an 8-bit checksum.
REQ-026 SHALL, after the 4th byte transfers, increment the address modulo 2^ADDR_WIDTH (0x3FF+1 -> 0x000 at default) and decrement the remaining count; go to READ if the count is nonzero, else to CHECKSUM.
REQ-027 SHALL, in CHECKSUM, present the accumulated checksum; on transfer go to DONE.
REQ-028 SHALL, in DONE, assert oDone for exactly one cycle, then return to IDLE.
REQ-029 SHALL hold oBusy high in every state except IDLE.
REQ-030 SHALL drive oRamReadEnable and oUartTxByteAvailable low in IDLE, READ, LATCH and DONE.

Reset
REQ-031 SHALL, while iGlobalReset==0, force IDLE at once (asynchronously) and drive oRamAddr=0, oRamReadEnable=0, oUartTx=8'h00, oUartTxByteAvailable=0, oBusy=0, oDone=0, with the checksum, count and shift register all 0.
REQ-032 SHALL, on reset asserted mid-dump, abandon the frame with no oDone pulse; after release, stay in IDLE until a new iStart.

Verification
REQ-033 SHALL pass the basic dump: RAM[0]=6, RAM[1]=8, base 0, count 2, ready tied 1 -> bytes A5,00,00,00,06,00,00,00,08,0E, then one oDone pulse.
REQ-034 SHALL pass backpressure: the same dump with iUartTxReady low for 5 cycles while byte 06 is presented -> 06 held stable and valid throughout, identical byte sequence, no duplicates.
REQ-035 SHALL pass wrap-around: base 0x3FF, count 2, RAM[0x3FF]=32'hDEADBEEF, RAM[0]=32'h00000001 -> read addresses 0x3FF then 0x000; bytes A5,DE,AD,BE,EF,00,00,00,01, then checksum 0x23.
REQ-036 SHALL pass zero count: iStart with count 0 -> no byte valid, no RAM read, oDone exactly 2 cycles after iStart.
REQ-037 SHALL pass start-while-busy: iStart pulsed during SEND -> no effect; exactly one frame and one oDone.
REQ-038 SHALL pass mid-frame reset: iGlobalReset low during the 3rd data byte -> all outputs reach reset values without a clock edge, no oDone; a fresh dump afterwards is correct.
